dual_slope_sequencer: RTL and testbench

- Conversion controller for the MC14433-style dual-slope ADC model.
- Sequences the analog switch phases: auto-zero, then integrate, then de-integrate.
- Counts de-integrate clocks in BCD (3½ digits, 0000–1999) and latches the result with polarity and overrange.
- Sits between the clock/reset source (CP0/R_clock) and the integrator/comparator datapath; comparator output D is its only analog-side input.

---
 rtl/dual_slope_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_dual_slope_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_sequencer.sv
// dual_slope_sequencer
//   Conversion controller for an MC14433-style dual-slope ADC. It steps the
//   analog switches through auto-zero, signal integrate and reference
//   de-integrate. De-integrate clocks are counted in BCD (0000..1999). The
//   count is latched together with polarity and overrange.
//
// Parameters
//   T_AZ      auto-zero length in CP0 cycles (1..65535)
//   T_INT     signal-integrate length in CP0 cycles (1..65535)
//   SCAN_DIV  CP0 cycles per digit-strobe slot (digit scan build only)
//
// Ports
//   CP0       system clock, rising edge
//   R_clock   synchronous reset, active-high
//   DU        start/update request (level, sampled in IDLE and LATCH)
//   CONT      1 = free-running conversions, 0 = single-shot on DU
//   D         comparator output, asynchronous (1 = not yet crossed zero)
//   sw_az     auto-zero switch enable
//   sw_int    input-integrate switch enable
//   sw_deint  reference de-integrate switch enable
//   busy      high while a conversion is in progress (AZ/INT/DEINT/LATCH)
//   eoc       end-of-conversion, one-cycle pulse
//   pol       polarity of the last result
//   ovr       overrange flag of the last result
//   result    BCD {thousands, hundreds, tens, units}
//   ds, q     digit strobe (one-hot) and selected digit value; these ports
//             exist only when the DIGIT_SCAN_EN macro is defined
module dual_slope_sequencer #(
  parameter int unsigned T_AZ     = 4000,
  parameter int unsigned T_INT    = 4000,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic        CP0,
  input  logic        R_clock,
  input  logic        DU,
  input  logic        CONT,
  input  logic        D,
  output logic        sw_az,
  output logic        sw_int,
  output logic        sw_deint,
  output logic        busy,
  output logic        eoc,
  output logic        pol,
  output logic        ovr,
  output logic [15:0] result
`ifdef DIGIT_SCAN_EN
  ,
  output logic [3:0]  ds,
  output logic [3:0]  q
`endif
);

  localparam logic [15:0] AZ_LAST  = 16'(T_AZ - 1);
  localparam logic [15:0] INT_LAST = 16'(T_INT - 1);
  localparam logic [15:0] BCD_MAX  = 16'h1999;

  if (T_AZ == 0 || T_AZ > 65535) begin : g_bad_t_az
    $error("T_AZ must be in 1..65535");
  end
  if (T_INT == 0 || T_INT > 65535) begin : g_bad_t_int
    $error("T_INT must be in 1..65535");
  end
  if (SCAN_DIV == 0 || SCAN_DIV > 65536) begin : g_bad_scan_div
    $error("SCAN_DIV must be in 1..65536");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_AZ,
    S_INT,
    S_DEINT,
    S_LATCH
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic [15:0] cnt;
  logic        pol_shadow;
  logic        d_p0;
  logic        d_p1;

  // Four-digit BCD increment with decade carry. The caller stops at 1999, so
  // the thousands digit never goes past 1.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CP0) begin
    if (R_clock) begin
      state      <= S_IDLE;
      timer      <= '0;
      cnt        <= '0;
      pol_shadow <= 1'b0;
      d_p0       <= 1'b1;
      d_p1       <= 1'b1;
      sw_az      <= 1'b1;
      sw_int     <= 1'b0;
      sw_deint   <= 1'b0;
      busy       <= 1'b0;
      eoc        <= 1'b0;
      pol        <= 1'b0;
      ovr        <= 1'b0;
      result     <= '0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer for the asynchronous comparator
      d_p0 <= D;
      d_p1 <= d_p0;
      eoc  <= 1'b0;
      // Stage p1 -> FSM: every decision below uses the synchronized d_p1
      case (state)
        S_IDLE: begin
          if (DU || CONT) begin
            state <= S_AZ;
            timer <= '0;
            sw_az <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_AZ: begin
          if (timer == AZ_LAST) begin
            state  <= S_INT;
            timer  <= '0;
            sw_az  <= 1'b0;
            sw_int <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_INT: begin
          if (timer == INT_LAST) begin
            state      <= S_DEINT;
            timer      <= '0;
            cnt        <= '0;
            pol_shadow <= d_p1;
            sw_int     <= 1'b0;
            sw_deint   <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_DEINT: begin
          // Zero crossing ends the phase without counting. The overrange exit
          // is reached only with d_p1 still high, so d_p1 doubles as the flag.
          if (!d_p1 || cnt == BCD_MAX) begin
            state    <= S_LATCH;
            sw_deint <= 1'b0;
            eoc      <= 1'b1;
            result   <= cnt;
            ovr      <= d_p1;
            pol      <= pol_shadow;
          end else begin
            cnt <= bcd_inc(cnt);
          end
        end
        S_LATCH: begin
          timer <= '0;
          sw_az <= 1'b1;
          if (CONT || DU) begin
            state <= S_AZ;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          timer    <= '0;
          sw_az    <= 1'b1;
          sw_int   <= 1'b0;
          sw_deint <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIGIT_SCAN_EN
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] scan_cnt;

  // Free-running strobe: it rotates thousands -> units regardless of the
  // FSM state.
  always_ff @(posedge CP0) begin
    if (R_clock) begin
      scan_cnt <= '0;
      ds       <= 4'b1000;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      ds       <= {ds[0], ds[3:1]};
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    q = 4'd0;
    case (ds)
      4'b1000: q = result[15:12];
      4'b0100: q = result[11:8];
      4'b0010: q = result[7:4];
      4'b0001: q = result[3:0];
      default: q = 4'd0;
    endcase
  end
`endif

endmodule

// File: tb/tb_dual_slope_sequencer.sv
module tb_dual_slope_sequencer;

  logic        CP0 = 1'b0;
  logic        R_clock;
  logic        DU;
  logic        CONT;
  logic        D;
  logic        sw_az;
  logic        sw_int;
  logic        sw_deint;
  logic        busy;
  logic        eoc;
  logic        pol;
  logic        ovr;
  logic [15:0] result;
`ifdef DIGIT_SCAN_EN
  logic [3:0]  ds;
  logic [3:0]  q;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 CP0 = ~CP0;

  dual_slope_sequencer #(
    .T_AZ    (8),
    .T_INT   (10),
    .SCAN_DIV(4)
  ) dut (
    .CP0     (CP0),
    .R_clock (R_clock),
    .DU      (DU),
    .CONT    (CONT),
    .D       (D),
    .sw_az   (sw_az),
    .sw_int  (sw_int),
    .sw_deint(sw_deint),
    .busy    (busy),
    .eoc     (eoc),
    .pol     (pol),
    .ovr     (ovr),
    .result  (result)
`ifdef DIGIT_SCAN_EN
    ,
    .ds      (ds),
    .q       (q)
`endif
  );

  task automatic tick();
    @(posedge CP0);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts the AZ cycles and then the INT cycles. It leaves the bench just
  // after the edge that enters DEINT.
  task automatic az_int_phases(input string tag);
    int n;
    n = 0;
    while (sw_az && n < 100) begin n++; tick(); end
    check({tag, " az_len"}, 16'(n), 16'd8);
    check({tag, " int_on"}, {15'd0, sw_int}, 16'd1);
    n = 0;
    while (sw_int && n < 100) begin n++; tick(); end
    check({tag, " int_len"}, 16'(n), 16'd10);
    check({tag, " deint_on"}, {15'd0, sw_deint}, 16'd1);
  endtask

  // D_s lags D by two edges. D is dropped after the (n-2)th DEINT edge, so
  // exactly n DEINT cycles see D_s==1. With ov set, D stays high for 2000
  // DEINT cycles.
  task automatic deint_phase(input string tag, input int n, input bit ov,
                             input logic [15:0] exp_res, input bit exp_pol);
    if (ov) begin
      repeat (1999) tick();
    end else begin
      repeat (n - 2) tick();
      D = 1'b0;
      repeat (2) tick();
    end
    check({tag, " eoc_early"}, {15'd0, eoc}, 16'd0);
    check({tag, " deint_held"}, {15'd0, sw_deint}, 16'd1);
    tick();
    check({tag, " eoc"}, {15'd0, eoc}, 16'd1);
    check({tag, " result"}, result, exp_res);
    check({tag, " ovr"}, {15'd0, ovr}, {15'd0, ov});
    check({tag, " pol"}, {15'd0, pol}, {15'd0, exp_pol});
    check({tag, " latch_sw"}, {13'd0, sw_az, sw_int, sw_deint}, 16'd0);
    check({tag, " latch_busy"}, {15'd0, busy}, 16'd1);
  endtask

  task automatic single_conv(input string tag, input int n, input bit ov,
                             input logic [15:0] exp_res);
    D = 1'b1;
    repeat (3) tick();
    DU = 1'b1;
    tick();
    DU = 1'b0;
    check({tag, " busy"}, {15'd0, busy}, 16'd1);
    az_int_phases(tag);
    deint_phase(tag, n, ov, exp_res, 1'b1);
    tick();
    check({tag, " idle_eoc"}, {15'd0, eoc}, 16'd0);
    check({tag, " idle_busy"}, {15'd0, busy}, 16'd0);
    check({tag, " idle_sw"}, {13'd0, sw_az, sw_int, sw_deint}, 16'd4);
    check({tag, " hold"}, result, exp_res);
  endtask

  initial begin
    R_clock = 1'b1;
    DU      = 1'b0;
    CONT    = 1'b0;
    D       = 1'b1;
    repeat (2) tick();
    check("rst sw", {13'd0, sw_az, sw_int, sw_deint}, 16'd4);
    check("rst busy", {15'd0, busy}, 16'd0);
    check("rst eoc", {15'd0, eoc}, 16'd0);
    check("rst pol_ovr", {14'd0, pol, ovr}, 16'd0);
    check("rst result", result, 16'h0000);
    R_clock = 1'b0;
    repeat (3) tick();
    check("idle stays", {15'd0, busy}, 16'd0);

    single_conv("c37", 37, 1'b0, 16'h0037);
    single_conv("c100", 100, 1'b0, 16'h0100);
    single_conv("c1099", 1099, 1'b0, 16'h1099);
    single_conv("ovr", 2000, 1'b1, 16'h1999);

    // Comparator already low well before DEINT: pol=0 and a zero count.
    D = 1'b0;
    repeat (3) tick();
    DU = 1'b1;
    tick();
    DU = 1'b0;
    az_int_phases("z0");
    tick();
    check("z0 eoc", {15'd0, eoc}, 16'd1);
    check("z0 result", result, 16'h0000);
    check("z0 pol", {15'd0, pol}, 16'd0);
    check("z0 ovr", {15'd0, ovr}, 16'd0);
    tick();

    // D_s still high on the last INT cycle, low on the first DEINT cycle.
    D = 1'b1;
    repeat (3) tick();
    DU = 1'b1;
    tick();
    DU = 1'b0;
    begin
      int n;
      n = 0;
      while (sw_az && n < 100) begin n++; tick(); end
      check("z1 az_len", 16'(n), 16'd8);
    end
    repeat (8) tick();
    D = 1'b0;
    repeat (2) tick();
    check("z1 deint_on", {15'd0, sw_deint}, 16'd1);
    tick();
    check("z1 eoc", {15'd0, eoc}, 16'd1);
    check("z1 result", result, 16'h0000);
    check("z1 pol", {15'd0, pol}, 16'd1);
    tick();

    // Continuous mode: AZ follows LATCH directly, then reset in mid-INT.
    D = 1'b1;
    repeat (3) tick();
    CONT = 1'b1;
    tick();
    check("cont start", {15'd0, busy}, 16'd1);
    az_int_phases("cont1");
    deint_phase("cont1", 5, 1'b0, 16'h0005, 1'b1);
    D = 1'b1;
    tick();
    check("cont reaz sw", {13'd0, sw_az, sw_int, sw_deint}, 16'd4);
    check("cont reaz busy", {15'd0, busy}, 16'd1);
    check("cont reaz eoc", {15'd0, eoc}, 16'd0);
    begin
      int n;
      n = 0;
      while (sw_az && n < 100) begin n++; tick(); end
      check("cont2 az_len", 16'(n), 16'd8);
    end
    repeat (3) tick();
    check("cont2 mid_int", {13'd0, sw_az, sw_int, sw_deint}, 16'd2);
    R_clock = 1'b1;
    tick();
    check("midrst sw", {13'd0, sw_az, sw_int, sw_deint}, 16'd4);
    check("midrst busy", {15'd0, busy}, 16'd0);
    check("midrst eoc", {15'd0, eoc}, 16'd0);
    check("midrst pol_ovr", {14'd0, pol, ovr}, 16'd0);
    check("midrst result", result, 16'h0000);
    CONT    = 1'b0;
    R_clock = 1'b0;
    repeat (2) tick();
    check("midrst idle", {15'd0, busy}, 16'd0);

    single_conv("c1234", 1234, 1'b0, 16'h1234);

`ifdef DIGIT_SCAN_EN
    begin
      logic [3:0] exp_ds [4];
      logic [3:0] exp_q  [4];
      int n;
      exp_ds[0] = 4'b1000; exp_ds[1] = 4'b0100; exp_ds[2] = 4'b0010; exp_ds[3] = 4'b0001;
      exp_q[0]  = 4'd1;    exp_q[1]  = 4'd2;    exp_q[2]  = 4'd3;    exp_q[3]  = 4'd4;
      n = 0;
      while (ds !== 4'b0001 && n < 40) begin n++; tick(); end
      n = 0;
      while (ds === 4'b0001 && n < 40) begin n++; tick(); end
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          check("scan ds", {12'd0, ds}, {12'd0, exp_ds[s]});
          check("scan q", {12'd0, q}, {12'd0, exp_q[s]});
          tick();
        end
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
